ste_snd_dma_sink: RTL and testbench
===================================

Name: ste_snd_dma_sink

Overview:
- Receiving end of the sound-DMA protocol.
- The memory controller drives sound-DMA loads (sload) with RAM words on sdata. This block buffers those words in a 4-word FIFO and raises sreq while it has room.
- It plays the buffered words out as signed 8-bit PCM (mono or stereo) at one of four sample rates derived from clk32.
- It sits in the shifter-side sound path and feeds the audio mixer/DAC.

Parameters:
- DEPTH, 4: FIFO depth in 16-bit words. Must be a power of 2, at least 4.
- DIV50K, 640: clk32 cycles per sample at rate 3 (~50 kHz). Rates 2, 1 and 0 use 2x, 4x and 8x this value.

Ports:
- clk32  in  1  system clock, 32 MHz; all logic is on its rising edge.
- por  in  1  reset, synchronous, active-high.
- sndon  in  1  sound DMA enabled; low flushes the block.
- stereo  in  1  1 = stereo (high byte left, low byte right); 0 = mono.
- rate  in  2  sample rate: 0=6.25k, 1=12.5k, 2=25k, 3=50k.
- sload  in  1  one-clk32 strobe; sdata is valid in this cycle.
- sdata  in  16  DMA word from RAM.
- sreq  out  1  DMA request to the memory controller.
- snd_l  out  8  left sample, signed.
- snd_r  out  8  right sample, signed.
- stick  out  1  one-cycle pulse when snd_l/snd_r update.
- underrun  out  1  sticky: a tick found no data.
- overflow  out  1  sticky: an sload arrived while the FIFO was full.
- fcnt  out  3  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (por=1): FIFO empty, fcnt=0, sreq=0, snd_l=snd_r=0, stick=0, underrun=overflow=0, prescaler=0, byte phase=high.
- sndon=0 has the same effect as reset on all state except the sticky flags, which hold. por has priority over sndon.
- Sticky flags clear only on por, or on a rising edge of sndon.
- sreq is registered. In cycle n+1 it equals sndon & (fcnt <= DEPTH-2), evaluated from cycle-n state. This leaves one word of slack for a load already in flight.
- Write: when sload=1 and the FIFO is not full, push sdata. fcnt increments on the next edge.
- Write when full: the word is dropped, fcnt is unchanged, overflow is set.
- Prescaler: counts 0..N-1, where N = DIV50K << (3-rate). A tick occurs when the count reaches N-1, and the count then wraps to 0.
- A change of rate takes effect at the next wrap. If the current count is already at or above the new N-1, the counter wraps on the next cycle.
- The prescaler runs only while sndon=1.
- Stereo tick with FIFO non-empty:
  - snd_l = word[15:8], snd_r = word[7:0].
  - pop the word.
- Mono tick with FIFO non-empty:
  - phase high: snd_l = snd_r = word[15:8]; no pop; phase becomes low.
  - phase low: snd_l = snd_r = word[7:0]; pop; phase becomes high.
- Tick with FIFO empty: snd_l/snd_r hold their previous values, underrun is set, and stick still pulses.
- stick pulses in the same cycle the outputs update (registered), one cycle after the prescaler wrap.
- Simultaneous push and pop (FIFO not full): both occur and fcnt is unchanged.
- A push into an empty FIFO cannot be popped in the same cycle. The tick sees empty and underrun is set.
- Changing stereo mid-stream: takes effect at the next tick; phase is forced to high when stereo=1.
- The FIFO pointers are log2(DEPTH) bits wide and wrap naturally. fcnt is log2(DEPTH)+1 bits wide.

Decomposition:
- Package ste_snd_pkg:
  - rate encoding constants RATE_6K25..RATE_50K;
  - DIV50K default;
  - function rate_div(rate) returning N;
  - FIFO depth constant.
- Sub-module snd_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH and width 16. Pop of empty and push of full are ignored internally.
- The top-level module holds the prescaler, byte phase, sreq register, output registers and sticky flags.

Test Plan:
- por pulse, then sndon=1 with no loads: sreq=1 one cycle later; at rate=3 the first stick is 641 cycles after sndon, with underrun=1 and snd_l=snd_r=0.
- Stereo, rate=3: load 0x7F80, 0x0102, then a tick: snd_l=0x7F, snd_r=0x80; next tick snd_l=0x01, snd_r=0x02; fcnt goes 2→1→0.
- Mono: load 0x1234, then ticks: outputs 0x12/0x12, then 0x34/0x34; the pop happens only on the second tick.
- Load 3 words back-to-back: sreq drops the cycle after fcnt reaches 3; a 5th load while full sets overflow and fcnt stays 4.
- Push and pop in the same cycle at fcnt=2: fcnt stays 2 and the data order is preserved.
- Drop sndon mid-stream with fcnt=3: the next cycle has fcnt=0, sreq=0, outputs 0, and sticky flags held. Then switch rate 3→0: the tick spacing becomes 5120 cycles after the next wrap.

Source files
------------

// File: rtl/ste_snd_pkg.sv
// Shared constants and helpers for the sound-DMA sink.
package ste_snd_pkg;

  // Sample-rate encodings carried on the rate input.
  localparam logic [1:0] RATE_6K25 = 2'd0;
  localparam logic [1:0] RATE_12K5 = 2'd1;
  localparam logic [1:0] RATE_25K  = 2'd2;
  localparam logic [1:0] RATE_50K  = 2'd3;

  // clk32 cycles per sample at the fastest rate.
  localparam int unsigned DIV50K_DEF = 640;

  // Default FIFO depth in 16-bit DMA words.
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SAMPLE_W = 8;

  // Which byte of the head word a mono tick plays next.
  typedef enum logic {
    PhHigh = 1'b0,
    PhLow  = 1'b1
  } phase_e;

  // Prescaler period in clk32 cycles: each step down in rate doubles it.
  function automatic int unsigned rate_div(input logic [1:0] rate, input int unsigned div50k);
    int unsigned n;
    case (rate)
      RATE_6K25: n = div50k * 8;
      RATE_12K5: n = div50k * 4;
      RATE_25K:  n = div50k * 2;
      default:   n = div50k;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snd_fifo.sv
// Small synchronous FIFO for DMA words. Pushes when full and pops when empty
// are ignored; clr empties it like a reset.
module snd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ste_snd_dma_sink.sv
// Sound-DMA sink: buffers DMA words, requests more while there is room, and
// plays them out as signed 8-bit PCM at a prescaled sample rate.
module ste_snd_dma_sink
  import ste_snd_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned DIV50K = DIV50K_DEF
) (
  input  logic                     clk32,
  input  logic                     por,
  input  logic                     sndon,
  input  logic                     stereo,
  input  logic [1:0]               rate,
  input  logic                     sload,
  input  logic [WORD_W-1:0]        sdata,
  output logic                     sreq,
  output logic [SAMPLE_W-1:0]      snd_l,
  output logic [SAMPLE_W-1:0]      snd_r,
  output logic                     stick,
  output logic                     underrun,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fcnt
);

  localparam int unsigned CW = $clog2(DIV50K * 8);
  localparam int unsigned FW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       cnt_last;
  logic                tick;
  phase_e              phase_q, phase_d;
  logic                sreq_q, sreq_d;
  logic [SAMPLE_W-1:0] snd_l_q, snd_l_d;
  logic [SAMPLE_W-1:0] snd_r_q, snd_r_d;
  logic                stick_q, stick_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic                sndon_q;

  logic [WORD_W-1:0]   f_rdata;
  logic                f_full, f_empty;
  logic [FW-1:0]       f_count;
  logic                f_push, f_pop;

  // Compared live against the current rate, so a shorter period wraps at once
  // if the count has already passed it.
  assign cnt_last = CW'(rate_div(rate, DIV50K) - 1);
  assign tick     = sndon & (cnt_q >= cnt_last);

  // Stereo consumes a word per tick; mono only after the low byte.
  assign f_push = sndon & sload;
  assign f_pop  = tick & ~f_empty & (stereo | (phase_q == PhLow));

  snd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk32),
    .rst   (por),
    .clr   (~sndon),
    .push  (f_push),
    .wdata (sdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Next state for prescaler, byte phase, request, samples and sticky flags.
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    sreq_d     = sreq_q;
    snd_l_d    = snd_l_q;
    snd_r_d    = snd_r_q;
    stick_d    = 1'b0;
    underrun_d = underrun_q;
    overflow_d = overflow_q;

    if (!sndon) begin
      // Flush everything except the sticky flags.
      cnt_d   = '0;
      phase_d = PhHigh;
      sreq_d  = 1'b0;
      snd_l_d = '0;
      snd_r_d = '0;
    end else begin
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      // One word of slack is kept for a load already in flight.
      sreq_d  = (f_count <= FW'(DEPTH - 2));
      stick_d = tick;

      if (!sndon_q) begin
        underrun_d = 1'b0;
        overflow_d = 1'b0;
      end else begin
        if (sload && f_full) overflow_d = 1'b1;
        if (tick && f_empty) underrun_d = 1'b1;
      end

      if (tick && !f_empty) begin
        if (stereo) begin
          snd_l_d = f_rdata[15:8];
          snd_r_d = f_rdata[7:0];
        end else if (phase_q == PhHigh) begin
          snd_l_d = f_rdata[15:8];
          snd_r_d = f_rdata[15:8];
          phase_d = PhLow;
        end else begin
          snd_l_d = f_rdata[7:0];
          snd_r_d = f_rdata[7:0];
          phase_d = PhHigh;
        end
      end

      if (stereo) phase_d = PhHigh;
    end
  end

  // State registers with synchronous power-on reset.
  always_ff @(posedge clk32) begin
    if (por) begin
      cnt_q      <= '0;
      phase_q    <= PhHigh;
      sreq_q     <= 1'b0;
      snd_l_q    <= '0;
      snd_r_q    <= '0;
      stick_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      sndon_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      sreq_q     <= sreq_d;
      snd_l_q    <= snd_l_d;
      snd_r_q    <= snd_r_d;
      stick_q    <= stick_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      sndon_q    <= sndon;
    end
  end

  assign sreq     = sreq_q;
  assign snd_l    = snd_l_q;
  assign snd_r    = snd_r_q;
  assign stick    = stick_q;
  assign underrun = underrun_q;
  assign overflow = overflow_q;
  assign fcnt     = f_count;

endmodule

// File: tb/tb_ste_snd_dma_sink.sv
// Directed bench for the sound-DMA sink: a table of load vectors plus
// hand-written tick sequences.
module tb_ste_snd_dma_sink;

  logic        clk32 = 1'b0;
  logic        por, sndon, stereo, sload;
  logic [1:0]  rate;
  logic [15:0] sdata;
  logic        sreq, stick, underrun, overflow;
  logic [7:0]  snd_l, snd_r;
  logic [2:0]  fcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk32 = ~clk32;

  ste_snd_dma_sink dut (
    .clk32    (clk32),
    .por      (por),
    .sndon    (sndon),
    .stereo   (stereo),
    .rate     (rate),
    .sload    (sload),
    .sdata    (sdata),
    .sreq     (sreq),
    .snd_l    (snd_l),
    .snd_r    (snd_r),
    .stick    (stick),
    .underrun (underrun),
    .overflow (overflow),
    .fcnt     (fcnt)
  );

  typedef struct {
    logic        ld;
    logic [15:0] d;
    logic [2:0]  fcnt;
    logic        sreq;
    logic        ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk32);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Steps until stick is seen; n is the number of edges taken.
  task automatic wait_stick(input string name, input int limit, output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < limit) begin
      step();
      n++;
      if (stick) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no stick within %0d cycles", name, limit);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sload = vecs[i].ld;
      sdata = vecs[i].d;
      step();
      sload = 1'b0;
      check($sformatf("vec%0d_fcnt", i), 32'(fcnt), 32'(vecs[i].fcnt));
      check($sformatf("vec%0d_sreq", i), 32'(sreq), 32'(vecs[i].sreq));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end
  endtask

  task automatic check_tick(input string name, input logic [7:0] l, input logic [7:0] r,
                            input logic [2:0] f);
    check({name, "_l"}, 32'(snd_l), 32'(l));
    check({name, "_r"}, 32'(snd_r), 32'(r));
    check({name, "_fcnt"}, 32'(fcnt), 32'(f));
  endtask

  initial begin
    int n;

    //            ld    data      fcnt  sreq  ovf
    vecs[0]  = '{1'b1, 16'h7F80, 3'd1, 1'b1, 1'b0};  // stereo words
    vecs[1]  = '{1'b1, 16'h0102, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h1234, 3'd1, 1'b1, 1'b0};  // mono word
    vecs[4]  = '{1'b1, 16'hA1A2, 3'd1, 1'b1, 1'b0};  // fill to full
    vecs[5]  = '{1'b1, 16'hB1B2, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'hC1C2, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 16'hD1D2, 3'd4, 1'b0, 1'b0};  // sreq falls after fcnt hit 3
    vecs[8]  = '{1'b1, 16'hE1E2, 3'd4, 1'b0, 1'b1};  // dropped, overflow
    vecs[9]  = '{1'b0, 16'h0000, 3'd4, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 16'h1111, 3'd1, 1'b1, 1'b1};  // refill before sndon drop
    vecs[11] = '{1'b1, 16'h2222, 3'd2, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 16'h3333, 3'd3, 1'b1, 1'b1};

    por = 1'b1; sndon = 1'b0; stereo = 1'b1; rate = 2'd3; sload = 1'b0; sdata = '0;
    repeat (3) step();
    check("rst_fcnt", 32'(fcnt), 0);
    check("rst_sreq", 32'(sreq), 0);
    check("rst_l", 32'(snd_l), 0);
    check("rst_r", 32'(snd_r), 0);
    check("rst_stick", 32'(stick), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_overflow", 32'(overflow), 0);
    por = 1'b0;
    step();
    check("idle_sreq", 32'(sreq), 0);

    // sndon applied in cycle 1; sreq in cycle 2; first stick in cycle 641.
    sndon = 1'b1;
    step();
    check("sreq_rise", 32'(sreq), 1);
    wait_stick("first_stick", 1000, n);
    check("first_stick_cycle", 32'(n + 2), 641);
    check("first_underrun", 32'(underrun), 1);
    check_tick("first", 8'h00, 8'h00, 3'd0);

    // Falling sndon holds sticky flags; rising clears them.
    sndon = 1'b0;
    step();
    check("off_underrun_held", 32'(underrun), 1);
    sndon = 1'b1;
    step();
    check("on_underrun_clr", 32'(underrun), 0);

    // Stereo playback.
    run_vecs(0, 2);
    wait_stick("st1", 1000, n);
    check_tick("st1", 8'h7F, 8'h80, 3'd1);
    wait_stick("st2", 1000, n);
    check("st_spacing", 32'(n), 640);
    check_tick("st2", 8'h01, 8'h02, 3'd0);

    // Mono playback: high byte first, pop only after the low byte.
    stereo = 1'b0;
    run_vecs(3, 3);
    wait_stick("mo1", 1000, n);
    check_tick("mo1", 8'h12, 8'h12, 3'd1);
    wait_stick("mo2", 1000, n);
    check_tick("mo2", 8'h34, 8'h34, 3'd0);
    check("mo_underrun", 32'(underrun), 0);

    // Fill, overflow, then drain with a push landing on a tick at fcnt=2.
    stereo = 1'b1;
    run_vecs(4, 9);
    wait_stick("fa", 1000, n);
    check_tick("fa", 8'hA1, 8'hA2, 3'd3);
    wait_stick("fb", 1000, n);
    check_tick("fb", 8'hB1, 8'hB2, 3'd2);
    repeat (639) step();
    sload = 1'b1;
    sdata = 16'hF1F2;
    step();
    sload = 1'b0;
    check("pp_stick", 32'(stick), 1);
    check_tick("pp", 8'hC1, 8'hC2, 3'd2);
    wait_stick("fd", 1000, n);
    check_tick("fd", 8'hD1, 8'hD2, 3'd1);
    wait_stick("ff", 1000, n);
    check_tick("ff", 8'hF1, 8'hF2, 3'd0);
    check("fill_underrun", 32'(underrun), 0);

    // Drop sndon with three words buffered.
    run_vecs(10, 12);
    sndon = 1'b0;
    step();
    check("drop_fcnt", 32'(fcnt), 0);
    check("drop_sreq", 32'(sreq), 0);
    check("drop_l", 32'(snd_l), 0);
    check("drop_r", 32'(snd_r), 0);
    check("drop_overflow_held", 32'(overflow), 1);
    check("drop_underrun_held", 32'(underrun), 0);

    // Restart, then switch to rate 0 right at a wrap.
    sndon = 1'b1;
    step();
    check("restart_overflow_clr", 32'(overflow), 0);
    check("restart_sreq", 32'(sreq), 1);
    wait_stick("r3", 1000, n);
    check("r3_spacing", 32'(n), 639);
    rate = 2'd0;
    wait_stick("r0", 6000, n);
    check("r0_spacing", 32'(n), 5120);

    // Shortening the period when the count is already past it wraps at once.
    repeat (1000) step();
    check("r0_no_stick", 32'(stick), 0);
    rate = 2'd3;
    step();
    check("early_wrap_stick", 32'(stick), 1);

    // Push into an empty FIFO on the tick edge: the tick still underruns.
    sndon = 1'b0;
    step();
    sndon = 1'b1;
    step();
    check("pe_underrun_clr", 32'(underrun), 0);
    repeat (638) step();
    sload = 1'b1;
    sdata = 16'h5566;
    step();
    sload = 1'b0;
    check("pe_stick", 32'(stick), 1);
    check("pe_underrun", 32'(underrun), 1);
    check_tick("pe", 8'h00, 8'h00, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
